// File: rtl/text_line_sequencer.sv
// text_line_sequencer: walks a "draw string" command character by character and
// glyph row by glyph row, fetching each character code from the text RAM and
// handing one row at a time to the glyph renderer, with right-edge clipping and
// a per-row watchdog on the renderer handshake.
module text_line_sequencer #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_AW      = 17,
    parameter int TXT_AW     = 10,
    parameter int GLYPH_ROWS = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [TXT_AW-1:0] cmd_base,
    input  logic [7:0]        cmd_len,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [3:0]        cmd_fg,
    input  logic [3:0]        cmd_bg,
    output logic [TXT_AW-1:0] txt_addr,
    output logic              txt_rd,
    input  logic [7:0]        txt_data,
    output logic              gl_start,
    output logic [FB_AW-1:0]  gl_addr,
    output logic [7:0]        gl_char,
    output logic [3:0]        gl_delta_y,
    output logic [3:0]        gl_fg,
    output logic [3:0]        gl_bg,
    input  logic              gl_done,
    output logic              busy,
    output logic              finish,
    output logic              err_timeout,
    output logic              clipped
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [TXT_AW-1:0] base;
    logic [7:0]        len;
    logic [9:0]        x0;
    logic [8:0]        y0;
    logic [7:0]        ci;
    logic [3:0]        row;
    logic [WD_W-1:0]   wd;

    // True when character idx would spill past the right edge of the framebuffer.
    function automatic logic clips(input logic [9:0] xo, input logic [7:0] idx);
        logic [12:0] right;
        right = 13'(xo) + {2'b00, idx, 3'b000} + 13'd7;
        return right >= 13'(FB_WIDTH);
    endfunction

    // Leftmost pixel of glyph row r of character idx; wraps modulo 2^FB_AW.
    function automatic logic [FB_AW-1:0] row_addr(input logic [8:0] yo, input logic [3:0] r,
                                                  input logic [9:0] xo, input logic [7:0] idx);
        logic [31:0] a;
        a = (32'(yo) + 32'(r)) * 32'(FB_WIDTH) + 32'(xo) + 32'({idx, 3'b000});
        return a[FB_AW-1:0];
    endfunction

    // Command sequencer: every output is a register, set on entry to the state
    // that owns it, so the clip decision is made before entering FETCH and no
    // read is issued for a character that will not be drawn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            finish      <= 1'b0;
            err_timeout <= 1'b0;
            clipped     <= 1'b0;
            txt_rd      <= 1'b0;
            txt_addr    <= '0;
            gl_start    <= 1'b0;
            gl_addr     <= '0;
            gl_char     <= '0;
            gl_delta_y  <= '0;
            gl_fg       <= '0;
            gl_bg       <= '0;
            base        <= '0;
            len         <= '0;
            x0          <= '0;
            y0          <= '0;
            ci          <= '0;
            row         <= '0;
            wd          <= '0;
        end else begin
            gl_start <= 1'b0;
            finish   <= 1'b0;
            txt_rd   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        base        <= cmd_base;
                        len         <= cmd_len;
                        x0          <= cmd_x;
                        y0          <= cmd_y;
                        gl_fg       <= cmd_fg;
                        gl_bg       <= cmd_bg;
                        err_timeout <= 1'b0;
                        clipped     <= 1'b0;
                        busy        <= 1'b1;
                        cmd_ready   <= 1'b0;
                        ci          <= '0;
                        row         <= '0;
                        if (cmd_len == 8'd0) begin
                            state <= S_DONE;
                        end else if (clips(cmd_x, 8'd0)) begin
                            clipped <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            txt_rd   <= 1'b1;
                            txt_addr <= cmd_base;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    gl_char    <= txt_data;
                    row        <= '0;
                    gl_start   <= 1'b1;
                    gl_delta_y <= '0;
                    gl_addr    <= row_addr(y0, 4'd0, x0, ci);
                    wd         <= '0;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    // A done arriving together with the start is not ours; ignore it.
                    wd    <= wd + WD_W'(1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (gl_done) begin
                        if (row != 4'(GLYPH_ROWS - 1)) begin
                            row        <= row + 4'd1;
                            gl_start   <= 1'b1;
                            gl_delta_y <= row + 4'd1;
                            gl_addr    <= row_addr(y0, row + 4'd1, x0, ci);
                            wd         <= '0;
                            state      <= S_ISSUE;
                        end else if (ci != len - 8'd1) begin
                            ci <= ci + 8'd1;
                            if (clips(x0, ci + 8'd1)) begin
                                clipped <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                txt_rd   <= 1'b1;
                                txt_addr <= base + TXT_AW'(ci + 8'd1);
                                state    <= S_FETCH;
                            end
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        // The count reaches TIMEOUT on this edge with no done seen.
                        err_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_DONE: begin
                    finish    <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_line_sequencer.sv
// Self-checking bench for text_line_sequencer: text RAM and glyph renderer stubs,
// a negedge monitor recording every start / read / finish, and a string-level
// reference model of which rows get drawn at which framebuffer addresses.
module tb_text_line_sequencer;

    localparam int FB_WIDTH   = 320;
    localparam int FB_AW      = 17;
    localparam int TXT_AW     = 10;
    localparam int GLYPH_ROWS = 8;
    localparam int TIMEOUT    = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [TXT_AW-1:0] cmd_base;
    logic [7:0]        cmd_len;
    logic [9:0]        cmd_x;
    logic [8:0]        cmd_y;
    logic [3:0]        cmd_fg;
    logic [3:0]        cmd_bg;
    logic [TXT_AW-1:0] txt_addr;
    logic              txt_rd;
    logic [7:0]        txt_data;
    logic              gl_start;
    logic [FB_AW-1:0]  gl_addr;
    logic [7:0]        gl_char;
    logic [3:0]        gl_delta_y;
    logic [3:0]        gl_fg;
    logic [3:0]        gl_bg;
    logic              gl_done;
    logic              busy;
    logic              finish;
    logic              err_timeout;
    logic              clipped;

    text_line_sequencer #(
        .FB_WIDTH(FB_WIDTH), .FB_AW(FB_AW), .TXT_AW(TXT_AW),
        .GLYPH_ROWS(GLYPH_ROWS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_fg(cmd_fg), .cmd_bg(cmd_bg),
        .txt_addr(txt_addr), .txt_rd(txt_rd), .txt_data(txt_data),
        .gl_start(gl_start), .gl_addr(gl_addr), .gl_char(gl_char), .gl_delta_y(gl_delta_y),
        .gl_fg(gl_fg), .gl_bg(gl_bg), .gl_done(gl_done),
        .busy(busy), .finish(finish), .err_timeout(err_timeout), .clipped(clipped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ch;
        int dy;
        int cyc;
    } start_t;

    start_t obs_q[$];
    int     rd_q[$];
    int     exp_addr_q[$];
    int     exp_char_q[$];
    int     exp_dy_q[$];
    int     exp_rd_q[$];
    bit     exp_clip;
    start_t s_tmp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int finish_cnt = 0;
    int finish_cyc = 0;
    int acc_cyc = 0;

    logic [7:0] ram [0:1023];
    bit stub_mute = 1'b0;
    bit stub_rand = 1'b0;
    int stub_lat  = 10;
    int rcnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Text RAM: one cycle read latency.
    always @(posedge clk) begin
        if (txt_rd) txt_data <= ram[txt_addr];
    end

    // Glyph renderer stub: done pulse lat cycles after the start cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt    <= 0;
            gl_done <= 1'b0;
        end else begin
            gl_done <= 1'b0;
            if (gl_start && !stub_mute) begin
                rcnt <= (stub_rand ? int'($urandom_range(2, 6)) : stub_lat) - 1;
            end else if (rcnt > 0) begin
                if (rcnt == 1) gl_done <= 1'b1;
                rcnt <= rcnt - 1;
            end
        end
    end

    // Monitor of DUT activity, sampled mid-cycle.
    always @(negedge clk) begin
        if (gl_start) begin
            s_tmp.addr = int'(gl_addr);
            s_tmp.ch   = int'(gl_char);
            s_tmp.dy   = int'(gl_delta_y);
            s_tmp.cyc  = cyc;
            obs_q.push_back(s_tmp);
        end
        if (txt_rd) rd_q.push_back(int'(txt_addr));
        if (finish) begin
            finish_cnt++;
            finish_cyc = cyc;
        end
    end

    // Reference: which characters get read, which rows get drawn and where.
    task automatic build_expected(input int base, input int len, input int x, input int y);
        exp_addr_q.delete();
        exp_char_q.delete();
        exp_dy_q.delete();
        exp_rd_q.delete();
        exp_clip = 1'b0;
        for (int i = 0; i < len; i++) begin
            int xi;
            int a;
            xi = x + 8 * i;
            if (xi + 7 >= FB_WIDTH) begin
                exp_clip = 1'b1;
                break;
            end
            a = (base + i) % 1024;
            exp_rd_q.push_back(a);
            for (int r = 0; r < GLYPH_ROWS; r++) begin
                exp_addr_q.push_back(((y + r) * FB_WIDTH + xi) % (1 << FB_AW));
                exp_char_q.push_back(int'(ram[a]));
                exp_dy_q.push_back(r);
            end
        end
    endtask

    task automatic issue_cmd(input int base, input int len, input int x, input int y,
                             input int fg, input int bg);
        @(negedge clk);
        obs_q.delete();
        rd_q.delete();
        finish_cnt = 0;
        cmd_base  = TXT_AW'(base);
        cmd_len   = 8'(len);
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_fg    = 4'(fg);
        cmd_bg    = 4'(bg);
        cmd_valid = 1'b1;
        acc_cyc   = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_finish(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (finish) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bit ok;
        int fc;
        int oc;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, finish, gl_start, txt_rd, err_timeout, clipped} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {cmd_ready, busy, finish, gl_start, txt_rd, err_timeout, clipped});
        end
        checks++;
        if (gl_addr !== '0 || txt_addr !== '0 || gl_char !== '0 || gl_delta_y !== '0) begin
            errors++;
            $display("FAIL reset_data: gl_addr=%0d txt_addr=%0d char=%0d dy=%0d want all 0",
                     gl_addr, txt_addr, gl_char, gl_delta_y);
        end
        reset = 1'b0;
        // Abort a command while it is waiting on the renderer.
        stub_rand = 1'b0;
        stub_lat  = 10;
        issue_cmd(0, 3, 0, 0, 1, 2);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_first_start: no gl_start within 50 cycles");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_before: busy=%b want 1", busy);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({gl_start, busy, finish, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_async: start/busy/finish/ready=%b want 0001",
                     {gl_start, busy, finish, cmd_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        fc = finish_cnt;
        oc = obs_q.size();
        repeat (30) @(negedge clk);
        checks++;
        if (finish_cnt !== fc || obs_q.size() !== oc) begin
            errors++;
            $display("FAIL reset_no_finish: finishes=%0d starts=%0d want %0d/%0d",
                     finish_cnt, obs_q.size(), fc, oc);
        end
    endtask

    task automatic test_string();
        bit ok;
        stub_rand = 1'b0;
        stub_lat  = 10;
        build_expected(16, 2, 8, 16);
        issue_cmd(16, 2, 8, 16, 5, 10);
        wait_finish(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL string_finish: no finish within 2000 cycles");
        end
        checks++;
        if (obs_q.size() !== 16) begin
            errors++;
            $display("FAIL string_starts: got %0d starts want 16", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].addr !== 5128 || obs_q[15].addr !== 7376) begin
                errors++;
                $display("FAIL string_addr_ends: got %0d/%0d want 5128/7376",
                         obs_q[0].addr, obs_q[15].addr);
            end
            checks++;
            if (obs_q[0].ch !== 8'h41 || obs_q[15].ch !== 8'h42) begin
                errors++;
                $display("FAIL string_chars: got %0h/%0h want 41/42", obs_q[0].ch, obs_q[15].ch);
            end
            checks++;
            if (obs_q[1].cyc - obs_q[0].cyc !== 11 || obs_q[8].cyc - obs_q[7].cyc !== 13) begin
                errors++;
                $display("FAIL string_spacing: got %0d/%0d want 11/13",
                         obs_q[1].cyc - obs_q[0].cyc, obs_q[8].cyc - obs_q[7].cyc);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_addr_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_addr_q[i] || obs_q[i].ch !== exp_char_q[i] ||
                obs_q[i].dy !== exp_dy_q[i]) begin
                errors++;
                $display("FAIL string_row%0d: got addr=%0d ch=%0h dy=%0d want %0d/%0h/%0d", i,
                         obs_q[i].addr, obs_q[i].ch, obs_q[i].dy,
                         exp_addr_q[i], exp_char_q[i], exp_dy_q[i]);
            end
        end
        checks++;
        if (rd_q.size() !== 2 || rd_q[0] !== 'h10 || rd_q[1] !== 'h11) begin
            errors++;
            $display("FAIL string_reads: got %0d reads want 0x10,0x11", rd_q.size());
        end
        checks++;
        if (finish_cnt !== 1 || clipped !== 1'b0 || err_timeout !== 1'b0 ||
            gl_fg !== 4'd5 || gl_bg !== 4'd10) begin
            errors++;
            $display("FAIL string_status: fin=%0d clip=%b to=%b fg=%0d bg=%0d want 1/0/0/5/10",
                     finish_cnt, clipped, err_timeout, gl_fg, gl_bg);
        end
    endtask

    task automatic test_empty();
        bit ok;
        issue_cmd(5, 0, 40, 40, 3, 4);
        wait_finish(20, ok);
        checks++;
        if (!ok || finish_cyc - acc_cyc !== 2) begin
            errors++;
            $display("FAIL empty_latency: seen=%b got %0d cycles want 2", ok, finish_cyc - acc_cyc);
        end
        checks++;
        if (rd_q.size() !== 0 || obs_q.size() !== 0 || finish_cnt !== 1) begin
            errors++;
            $display("FAIL empty_activity: reads=%0d starts=%0d fin=%0d want 0/0/1",
                     rd_q.size(), obs_q.size(), finish_cnt);
        end
        checks++;
        if (clipped !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL empty_sticky: clip=%b to=%b want 0/0", clipped, err_timeout);
        end
    endtask

    task automatic test_clip();
        bit ok;
        stub_lat = 3;
        build_expected('h100, 4, 304, 0);
        issue_cmd('h100, 4, 304, 0, 7, 8);
        wait_finish(2000, ok);
        checks++;
        if (!ok || finish_cnt !== 1) begin
            errors++;
            $display("FAIL clip_finish: seen=%b fin=%0d want 1/1", ok, finish_cnt);
        end
        checks++;
        if (obs_q.size() !== 16 || rd_q.size() !== 2) begin
            errors++;
            $display("FAIL clip_counts: starts=%0d reads=%0d want 16/2", obs_q.size(), rd_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_addr_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_addr_q[i] || obs_q[i].ch !== exp_char_q[i]) begin
                errors++;
                $display("FAIL clip_row%0d: got addr=%0d ch=%0h want %0d/%0h", i,
                         obs_q[i].addr, obs_q[i].ch, exp_addr_q[i], exp_char_q[i]);
            end
        end
        checks++;
        if (clipped !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL clip_sticky: clip=%b to=%b want 1/0", clipped, err_timeout);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        stub_mute = 1'b1;
        issue_cmd('h20, 1, 0, 0, 1, 1);
        wait_finish(400, ok);
        stub_mute = 1'b0;
        checks++;
        if (!ok || obs_q.size() !== 1) begin
            errors++;
            $display("FAIL timeout_finish: seen=%b starts=%0d want 1/1", ok, obs_q.size());
        end else begin
            checks++;
            if (finish_cyc - obs_q[0].cyc !== TIMEOUT + 1) begin
                errors++;
                $display("FAIL timeout_latency: got %0d want %0d",
                         finish_cyc - obs_q[0].cyc, TIMEOUT + 1);
            end
        end
        checks++;
        if (err_timeout !== 1'b1 || clipped !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: to=%b clip=%b want 1/0", err_timeout, clipped);
        end
    endtask

    task automatic test_wrap_busy();
        bit ok;
        stub_rand = 1'b0;
        stub_lat  = 4;
        build_expected('h3FF, 2, 0, 100);
        issue_cmd('h3FF, 2, 0, 100, 9, 6);
        cmd_base = TXT_AW'('h55);
        cmd_len  = 8'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_ready[%0d]: ready=%b busy=%b want 0/1", i, cmd_ready, busy);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_finish(2000, ok);
        checks++;
        if (!ok || rd_q.size() !== 2) begin
            errors++;
            $display("FAIL wrap_reads: seen=%b reads=%0d want 1/2", ok, rd_q.size());
        end else begin
            checks++;
            if (rd_q[0] !== 'h3FF || rd_q[1] !== 'h000) begin
                errors++;
                $display("FAIL wrap_addr: got %0h,%0h want 3ff,0", rd_q[0], rd_q[1]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_addr_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_addr_q[i] || obs_q[i].ch !== exp_char_q[i]) begin
                errors++;
                $display("FAIL wrap_row%0d: got addr=%0d ch=%0h want %0d/%0h", i,
                         obs_q[i].addr, obs_q[i].ch, exp_addr_q[i], exp_char_q[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() !== 16 || finish_cnt !== 1) begin
            errors++;
            $display("FAIL busy_not_queued: starts=%0d fin=%0d want 16/1", obs_q.size(), finish_cnt);
        end
    endtask

    task automatic test_random();
        bit ok;
        int base, len, x, y, fg, bg;
        stub_rand = 1'b1;
        for (int n = 0; n < 8; n++) begin
            base = int'($urandom_range(0, 1023));
            len  = int'($urandom_range(0, 5));
            x    = int'($urandom_range(0, 335));
            y    = int'($urandom_range(0, 511));
            fg   = int'($urandom_range(0, 15));
            bg   = int'($urandom_range(0, 15));
            build_expected(base, len, x, y);
            issue_cmd(base, len, x, y, fg, bg);
            wait_finish(3000, ok);
            checks++;
            if (!ok || finish_cnt !== 1) begin
                errors++;
                $display("FAIL rand%0d_finish: seen=%b fin=%0d want 1/1", n, ok, finish_cnt);
            end
            checks++;
            if (obs_q.size() !== exp_addr_q.size() || rd_q.size() !== exp_rd_q.size()) begin
                errors++;
                $display("FAIL rand%0d_counts: starts=%0d reads=%0d want %0d/%0d", n,
                         obs_q.size(), rd_q.size(), exp_addr_q.size(), exp_rd_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_addr_q.size(); i++) begin
                checks++;
                if (obs_q[i].addr !== exp_addr_q[i] || obs_q[i].ch !== exp_char_q[i] ||
                    obs_q[i].dy !== exp_dy_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_row%0d: got %0d/%0h/%0d want %0d/%0h/%0d", n, i,
                             obs_q[i].addr, obs_q[i].ch, obs_q[i].dy,
                             exp_addr_q[i], exp_char_q[i], exp_dy_q[i]);
                end
            end
            for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++) begin
                checks++;
                if (rd_q[i] !== exp_rd_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_read%0d: got %0h want %0h", n, i, rd_q[i], exp_rd_q[i]);
                end
            end
            checks++;
            if (clipped !== exp_clip || err_timeout !== 1'b0 ||
                gl_fg !== 4'(fg) || gl_bg !== 4'(bg)) begin
                errors++;
                $display("FAIL rand%0d_status: clip=%b to=%b fg=%0d bg=%0d want %b/0/%0d/%0d", n,
                         clipped, err_timeout, gl_fg, gl_bg, exp_clip, fg, bg);
            end
        end
        stub_rand = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_fg    = '0;
        cmd_bg    = '0;
        txt_data  = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom_range(0, 255));
        ram['h10] = 8'h41;
        ram['h11] = 8'h42;
        test_reset();
        test_string();
        test_empty();
        test_clip();
        test_timeout();
        test_wrap_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
